// File: rtl/wmd_pkg.sv
// Shared constants for the wmd alarm monitor: age codes,
// per-age normal ranges and channel state encoding.
package wmd_pkg;

  typedef enum logic [1:0] {
    AGE_INFANT = 2'd0,
    AGE_CHILD  = 2'd1,
    AGE_ADULT  = 2'd2,
    AGE_PREG   = 2'd3
  } age_e;

  localparam int NUM_CH   = 4;
  localparam int CH_ECG   = 0;
  localparam int CH_TEMP  = 1;
  localparam int CH_SPO2  = 2;
  localparam int CH_SLEEP = 3;

  typedef logic [7:0] thr_t;

  // [age][channel], inclusive limits
  localparam thr_t THR_LO [4][4] = '{
    '{8'd100, 8'd97, 8'd95, 8'd12},
    '{8'd70,  8'd97, 8'd95, 8'd9},
    '{8'd60,  8'd97, 8'd95, 8'd7},
    '{8'd70,  8'd97, 8'd95, 8'd7}
  };

  localparam thr_t THR_HI [4][4] = '{
    '{8'd160, 8'd100, 8'd100, 8'd17},
    '{8'd120, 8'd100, 8'd100, 8'd13},
    '{8'd100, 8'd99,  8'd100, 8'd9},
    '{8'd110, 8'd100, 8'd100, 8'd10}
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ALARM = 2'd2,
    ST_RECOV = 2'd3
  } chan_st_e;

  function automatic logic is_alarm(chan_st_e s);
    return (s == ST_ALARM) || (s == ST_RECOV);
  endfunction

endpackage

// File: rtl/wmd_alarm_monitor_if.sv
// Sample/alarm bundle between the sensor front end
// and the alert logic.
interface wmd_alarm_monitor_if #(
  parameter int DATA_W = 8
);
  logic              sample_valid;
  logic [1:0]        age_category;
  logic [DATA_W-1:0] ecgin;
  logic [DATA_W-1:0] tempin;
  logic [DATA_W-1:0] spo2in;
  logic [DATA_W-1:0] sleepin;
  logic              ack;
  logic              ecg;
  logic              temp;
  logic              spo2;
  logic              sleep;
  logic [3:0]        abn_now;
  logic              alarm_any;
  logic [15:0]       sample_cnt;

  modport master (
    output sample_valid, age_category,
    output ecgin, tempin, spo2in, sleepin, ack,
    input  ecg, temp, spo2, sleep,
    input  abn_now, alarm_any, sample_cnt
  );

  modport slave (
    input  sample_valid, age_category,
    input  ecgin, tempin, spo2in, sleepin, ack,
    output ecg, temp, spo2, sleep,
    output abn_now, alarm_any, sample_cnt
  );
endinterface

// File: rtl/wmd_chan_persist.sv
// One vital-sign channel: persistence/recovery
// hysteresis with optional latching and ack.
module wmd_chan_persist
  import wmd_pkg::*;
#(
  parameter int PERSIST = 3,
  parameter int CLR     = 2,
  parameter int LATCH   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic flush,
  input  logic abnormal,
  input  logic ack,
  output logic alarm
);

  localparam logic [3:0] P_LIM = 4'(PERSIST);
  localparam logic [3:0] C_LIM = 4'(CLR);

  chan_st_e   state_q, state_d, cur;
  logic [3:0] cnt_q, cnt_d, cnt_c, cnt_inc;
  logic       do_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign do_flush = valid && flush;
  assign cur      = do_flush ? ST_IDLE : state_q;
  assign cnt_c    = do_flush ? 4'd0 : cnt_q;
  assign cnt_inc  = cnt_c + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (valid) begin
      state_d = cur;
      cnt_d   = cnt_c;
      unique case (cur)
        ST_IDLE: begin
          if (abnormal) begin
            if (P_LIM == 4'd1) begin
              state_d = ST_ALARM;
              cnt_d   = '0;
            end else begin
              state_d = ST_PEND;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_PEND: begin
          if (!abnormal) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc >= P_LIM) begin
            state_d = ST_ALARM;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
        ST_ALARM: begin
          if (!abnormal) begin
            if (C_LIM == 4'd1 && LATCH == 0) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_RECOV;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_RECOV: begin
          if (abnormal) begin
            state_d = ST_ALARM;
            cnt_d   = '0;
          end else if (cnt_c >= C_LIM) begin
            cnt_d   = C_LIM;
          end else if (cnt_inc >= C_LIM) begin
            if (LATCH == 0) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d   = C_LIM;
            end
          end else begin
            cnt_d   = cnt_inc;
          end
        end
      endcase
    end
    // a fresh abnormal sample overrides the acknowledge
    if (LATCH != 0 && ack && cur == ST_RECOV &&
        cnt_c == C_LIM && !(valid && abnormal)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign alarm = is_alarm(state_q);

endmodule

// File: rtl/wmd_alarm_monitor.sv
// Clocked vital-sign monitor: per-age range checks
// feeding four persistence/hysteresis channels.
module wmd_alarm_monitor
  import wmd_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PERSIST = 3,
  parameter int CLR     = 2,
  parameter int LATCH   = 0
) (
  input logic clk,
  input logic rst,
  wmd_alarm_monitor_if.slave bus
);

  age_e              age_q;
  age_e              age_in;
  logic [3:0]        abn;
  logic [3:0]        abn_q;
  logic [15:0]       cnt_q;
  logic [3:0]        alarm;
  logic              flush;
  logic [DATA_W-1:0] val [NUM_CH];

  assign age_in         = age_e'(bus.age_category);
  assign val[CH_ECG]    = bus.ecgin;
  assign val[CH_TEMP]   = bus.tempin;
  assign val[CH_SPO2]   = bus.spo2in;
  assign val[CH_SLEEP]  = bus.sleepin;

  always_comb begin
    abn = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      abn[c] =
        (val[c] < DATA_W'(THR_LO[age_in][c])) ||
        (val[c] > DATA_W'(THR_HI[age_in][c]));
    end
  end

  assign flush = (age_in != age_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= AGE_INFANT;
      abn_q <= '0;
      cnt_q <= '0;
    end else if (bus.sample_valid) begin
      age_q <= age_in;
      abn_q <= abn;
      cnt_q <= cnt_q + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wmd_chan_persist #(
      .PERSIST (PERSIST),
      .CLR     (CLR),
      .LATCH   (LATCH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .valid    (bus.sample_valid),
      .flush    (flush),
      .abnormal (abn[g]),
      .ack      (bus.ack),
      .alarm    (alarm[g])
    );
  end

  assign bus.ecg        = alarm[CH_ECG];
  assign bus.temp       = alarm[CH_TEMP];
  assign bus.spo2       = alarm[CH_SPO2];
  assign bus.sleep      = alarm[CH_SLEEP];
  assign bus.alarm_any  = |alarm;
  assign bus.abn_now    = abn_q;
  assign bus.sample_cnt = cnt_q;

endmodule
